// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker: reads ID and timestamp words, compares them
// against expected values with bounded retries, and arbitrates host reads.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1539181635,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic        clock,
  input  logic        reset,
  output logic        sid_address,
  input  logic [31:0] sid_readdata,
  input  logic        host_read,
  input  logic        host_address,
  output logic        host_waitrequest,
  output logic        host_readdatavalid,
  output logic [31:0] host_readdata,
  input  logic        chk_start,
  output logic        chk_busy,
  output logic        chk_done,
  output logic        chk_pass,
  output logic        chk_fail,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, COMPARE, DONE} state_t;

  localparam logic [2:0] LAT       = 3'(READ_LATENCY);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

  state_t      state, state_next;
  logic [2:0]  phase;
  logic        phase_last;
  logic [3:0]  retry_cnt;
  logic        words_match;
  logic        start_ok;

  logic        hr_active;
  logic        hr_addr;
  logic [2:0]  hr_cnt;
  logic [2:0]  hr_cnt_cur;
  logic        hr_accept;
  logic        hr_drive;
  logic        hr_last;
  logic        host_inflight;

  // A read stays in flight through its readdatavalid cycle.
  assign host_inflight    = hr_active | host_readdatavalid;
  assign host_waitrequest = (state != DONE) || host_inflight || chk_start;
  assign start_ok         = (state == DONE) && chk_start && !host_inflight;
  assign hr_accept        = host_read && !host_waitrequest;
  assign hr_drive         = hr_accept | hr_active;
  assign hr_cnt_cur       = hr_accept ? '0 : hr_cnt;
  assign hr_last          = hr_drive && (hr_cnt_cur == LAT);
  assign phase_last       = (phase == LAT);
  assign words_match      = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
  assign chk_done         = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    chk_busy    = 1'b0;
    sid_address = 1'b0;
    case (state)
      IDLE:    state_next = RD_ID;
      RD_ID: begin
        chk_busy = 1'b1;
        if (phase_last) state_next = RD_TS;
      end
      RD_TS: begin
        chk_busy    = 1'b1;
        sid_address = 1'b1;
        if (phase_last) state_next = COMPARE;
      end
      COMPARE: begin
        chk_busy = 1'b1;
        if (words_match || (retry_cnt >= RETRY_MAX)) state_next = DONE;
        else                                         state_next = RD_ID;
      end
      DONE: begin
        if (start_ok) state_next = RD_ID;
        // Acceptance cycle drives the live address; later cycles the latched one.
        if (hr_accept)      sid_address = host_address;
        else if (hr_active) sid_address = hr_addr;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase     <= '0;
      retry_cnt <= '0;
      chk_pass  <= 1'b0;
      chk_fail  <= 1'b0;
      id_value  <= '0;
      ts_value  <= '0;
    end else begin
      if (state == RD_ID || state == RD_TS)
        phase <= phase_last ? '0 : phase + 3'd1;
      if (state == RD_ID && phase_last) id_value <= sid_readdata;
      if (state == RD_TS && phase_last) ts_value <= sid_readdata;
      if (state == COMPARE) begin
        if (words_match)                chk_pass  <= 1'b1;
        else if (retry_cnt < RETRY_MAX) retry_cnt <= retry_cnt + 4'd1;
        else                            chk_fail  <= 1'b1;
      end
      if (start_ok) begin
        chk_pass  <= 1'b0;
        chk_fail  <= 1'b0;
        retry_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hr_active          <= 1'b0;
      hr_addr            <= 1'b0;
      hr_cnt             <= '0;
      host_readdatavalid <= 1'b0;
      host_readdata      <= '0;
    end else begin
      host_readdatavalid <= 1'b0;
      if (hr_accept) hr_addr <= host_address;
      if (hr_last) begin
        host_readdata      <= sid_readdata;
        host_readdatavalid <= 1'b1;
        hr_active          <= 1'b0;
        hr_cnt             <= '0;
      end else if (hr_drive) begin
        hr_active <= 1'b1;
        hr_cnt    <= hr_cnt_cur + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench for sysid_boot_checker: three instances (latency 1, 0, 3)
// share clock/reset and a system-ID slave model with a programmable ID word.
module tb_sysid_boot_checker;

  localparam logic [31:0] EXP_TS = 32'd1539181635;

  logic        clock;
  logic        reset;
  logic [31:0] slave_id;
  logic        host_address;
  logic [2:0]  host_read, chk_start;
  logic [2:0]  sid_address, host_waitrequest, host_readdatavalid;
  logic [2:0]  chk_busy, chk_done, chk_pass, chk_fail;
  logic [31:0] sid_readdata  [3];
  logic [31:0] host_readdata [3];
  logic [31:0] id_value      [3];
  logic [31:0] ts_value      [3];

  int tests, failed;
  logic fail_seen, rdv_seen;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : (g == 1) ? 0 : 3;
    sysid_boot_checker #(
      .EXPECTED_ID(32'd0), .EXPECTED_TS(EXP_TS),
      .READ_LATENCY(LAT), .MAX_RETRY(2)
    ) dut (
      .clock(clock), .reset(reset),
      .sid_address(sid_address[g]), .sid_readdata(sid_readdata[g]),
      .host_read(host_read[g]), .host_address(host_address),
      .host_waitrequest(host_waitrequest[g]),
      .host_readdatavalid(host_readdatavalid[g]),
      .host_readdata(host_readdata[g]),
      .chk_start(chk_start[g]), .chk_busy(chk_busy[g]), .chk_done(chk_done[g]),
      .chk_pass(chk_pass[g]), .chk_fail(chk_fail[g]),
      .id_value(id_value[g]), .ts_value(ts_value[g])
    );
    assign sid_readdata[g] = sid_address[g] ? EXP_TS : slave_id;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic rd, addr, start;
    logic busy, done, pass, fail, wreq, rdv, sid;
  } vec_t;
  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; host_read = '0; chk_start = '0; host_address = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Returns the cycle offset (from the current cycle) at which chk_done rises.
  task automatic wait_done(input int idx, output int n);
    n = 0;
    #1;
    fail_seen |= chk_fail[idx];
    rdv_seen  |= host_readdatavalid[idx];
    while (!chk_done[idx] && n < 60) begin
      @(posedge clock);
      #2;
      n++;
      fail_seen |= chk_fail[idx];
      rdv_seen  |= host_readdatavalid[idx];
    end
  endtask

  task automatic check_reset_vals(input int idx, input string tag);
    check({tag, " busy"}, chk_busy[idx], 0);
    check({tag, " done"}, chk_done[idx], 0);
    check({tag, " pass"}, chk_pass[idx], 0);
    check({tag, " fail"}, chk_fail[idx], 0);
    check({tag, " rdv"},  host_readdatavalid[idx], 0);
    check({tag, " sid"},  sid_address[idx], 0);
    check({tag, " wreq"}, host_waitrequest[idx], 1);
    check({tag, " id"},   id_value[idx], 0);
    check({tag, " ts"},   ts_value[idx], 0);
    check({tag, " hrd"},  host_readdata[idx], 0);
  endtask

  initial begin
    int n, k;
    tests = 0; failed = 0; fail_seen = 1'b0; rdv_seen = 1'b0;
    slave_id = 32'd0;
    //            rd addr st  busy done pass fail wreq rdv sid
    vecs[0]  = '{0, 0, 0,  0, 0, 0, 0, 1, 0, 0};
    vecs[1]  = '{0, 0, 0,  1, 0, 0, 0, 1, 0, 0};
    vecs[2]  = '{0, 0, 0,  1, 0, 0, 0, 1, 0, 0};
    vecs[3]  = '{0, 0, 0,  1, 0, 0, 0, 1, 0, 1};
    vecs[4]  = '{0, 0, 0,  1, 0, 0, 0, 1, 0, 1};
    vecs[5]  = '{0, 0, 0,  1, 0, 0, 0, 1, 0, 0};
    vecs[6]  = '{0, 0, 0,  0, 1, 1, 0, 0, 0, 0};
    vecs[7]  = '{1, 1, 0,  0, 1, 1, 0, 0, 0, 1};
    vecs[8]  = '{0, 0, 0,  0, 1, 1, 0, 1, 0, 1};
    vecs[9]  = '{0, 0, 0,  0, 1, 1, 0, 1, 1, 0};
    vecs[10] = '{0, 0, 0,  0, 1, 1, 0, 0, 0, 0};
    vecs[11] = '{1, 0, 1,  0, 1, 1, 0, 1, 0, 0};
    vecs[12] = '{0, 0, 0,  1, 0, 0, 0, 1, 0, 0};
    vecs[13] = '{0, 0, 0,  1, 0, 0, 0, 1, 0, 0};
    vecs[14] = '{0, 0, 0,  1, 0, 0, 0, 1, 0, 1};

    // Matching slave, latency 1: auto-check timing, host read, start collision.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      if (i > 0) next_cycle();
      host_read[0] = vecs[i].rd; host_address = vecs[i].addr; chk_start[0] = vecs[i].start;
      #1;
      check($sformatf("v%0d busy", i), chk_busy[0], vecs[i].busy);
      check($sformatf("v%0d done", i), chk_done[0], vecs[i].done);
      check($sformatf("v%0d pass", i), chk_pass[0], vecs[i].pass);
      check($sformatf("v%0d fail", i), chk_fail[0], vecs[i].fail);
      check($sformatf("v%0d wreq", i), host_waitrequest[0], vecs[i].wreq);
      check($sformatf("v%0d rdv", i),  host_readdatavalid[0], vecs[i].rdv);
      check($sformatf("v%0d sid", i),  sid_address[0], vecs[i].sid);
      if (i == 6) check("v6 ts_value", ts_value[0], EXP_TS);
      if (vecs[i].rdv) check($sformatf("v%0d hrd", i), host_readdata[0], EXP_TS);
    end
    host_read = '0; chk_start = '0;

    // Latency 0 host read on instance 1 (in DONE since cycle 4).
    next_cycle();
    host_read[1] = 1'b1; host_address = 1'b1;
    #1;
    check("l0 accept wreq", host_waitrequest[1], 0);
    check("l0 accept sid", sid_address[1], 1);
    next_cycle();
    host_read[1] = 1'b0;
    #1;
    check("l0 strobe rdv", host_readdatavalid[1], 1);
    check("l0 strobe data", host_readdata[1], EXP_TS);
    check("l0 strobe wreq", host_waitrequest[1], 1);
    check("l0 strobe sid", sid_address[1], 0);
    next_cycle();
    #1;
    check("l0 after rdv", host_readdatavalid[1], 0);
    check("l0 after wreq", host_waitrequest[1], 0);
    check("l0 hold data", host_readdata[1], EXP_TS);

    // Same-cycle chk_start and host_read: checker wins.
    next_cycle();
    host_read[1] = 1'b1; chk_start[1] = 1'b1; host_address = 1'b0;
    #1;
    check("coll wreq", host_waitrequest[1], 1);
    next_cycle();
    host_read[1] = 1'b0; chk_start[1] = 1'b0;
    #1;
    check("coll done drop", chk_done[1], 0);
    check("coll busy", chk_busy[1], 1);
    rdv_seen = 1'b0;
    next_cycle();
    wait_done(1, n);
    check("coll no rdv", rdv_seen, 0);
    check("coll rerun pass", chk_pass[1], 1);

    // Latency 3 host read on instance 2, then a read cut short by reset.
    next_cycle();
    host_read[2] = 1'b1; host_address = 1'b1;
    #1;
    check("l3 accept wreq", host_waitrequest[2], 0);
    for (k = 1; k <= 4; k++) begin
      next_cycle();
      host_read[2] = 1'b0;
      #1;
      check($sformatf("l3 c%0d rdv", k), host_readdatavalid[2], (k == 4));
      check($sformatf("l3 c%0d sid", k), sid_address[2], (k < 4));
    end
    check("l3 data", host_readdata[2], EXP_TS);
    next_cycle();
    host_read[2] = 1'b1; host_address = 1'b1;
    next_cycle();
    host_read[2] = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check_reset_vals(2, "rst hr");
    rdv_seen = 1'b0;
    wait_done(2, n);
    check("rst hr redo cycle", n, 10);
    check("rst hr no rdv", rdv_seen, 0);
    check("rst hr redo pass", chk_pass[2], 1);

    // Reset asserted while instance 0 is in RD_TS.
    do_reset();
    for (k = 0; k < 3; k++) next_cycle();
    #1;
    check("rdts sid", sid_address[0], 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check_reset_vals(0, "rst rdts");
    wait_done(0, n);
    check("rst rdts redo cycle", n, 6);
    check("rst rdts redo pass", chk_pass[0], 1);

    // ID word never matches: MAX_RETRY=2 -> three passes then fail.
    slave_id = 32'd5;
    do_reset();
    fail_seen = 1'b0;
    wait_done(0, n);
    check("retry done cycle", n, 16);
    check("retry fail", chk_fail[0], 1);
    check("retry pass", chk_pass[0], 0);
    check("retry id", id_value[0], 5);

    // Mismatch on first pass only: pass on the second, fail never seen.
    do_reset();
    fail_seen = 1'b0;
    for (k = 0; k < 3; k++) next_cycle();
    slave_id = 32'd0;
    wait_done(0, n);
    check("retry1 done cycle", n + 3, 11);
    check("retry1 pass", chk_pass[0], 1);
    check("retry1 no fail", fail_seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sysid_boot_checker.md
SYSID_BOOT_CHECKER -- requirements
Module: sysid_boot_checker

Interface
REQ-001 SHALL provide parameter EXPECTED_ID, default 0: value required at system-ID address 0.
REQ-002 SHALL provide parameter EXPECTED_TS, default 1539181635: value required at system-ID address 1.
REQ-003 SHALL provide parameter READ_LATENCY, default 1, range 0..7: extra cycles `sid_address` is held before `sid_readdata` is sampled.
REQ-004 SHALL provide parameter MAX_RETRY, default 3, range 0..15: re-reads allowed after a mismatch.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 Ports, clock and reset first:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `sid_address` out 1: address to the system-ID slave.
- `sid_readdata` in 32: readdata from the system-ID slave.
- `host_read` in 1: host read request.
- `host_address` in 1: host word address.
- `host_waitrequest` out 1: host stall.
- `host_readdatavalid` out 1: host data-valid strobe.
- `host_readdata` out 32: host read data.
- `chk_start` in 1: re-run the check.
- `chk_busy` out 1: check in progress.
- `chk_done` out 1: check finished.
- `chk_pass` out 1: both words matched.
- `chk_fail` out 1: retries exhausted.
- `id_value` out 32: last ID word read.
- `ts_value` out 32: last timestamp word read.

Function
REQ-007 SHALL implement FSM states IDLE, RD_ID, RD_TS, COMPARE, DONE; reset enters IDLE.
REQ-008 IDLE SHALL go to RD_ID unconditionally on the next cycle (auto-check after reset).
REQ-009 Read phase (RD_ID with address 0, RD_TS with address 1):
- SHALL last exactly READ_LATENCY+1 cycles, counted by a phase counter.
- SHALL sample `sid_readdata` into `id_value` / `ts_value` at the final cycle.
- SHALL then advance RD_ID->RD_TS and RD_TS->COMPARE.
REQ-010 COMPARE SHALL last one cycle:
- both words equal -> DONE, with `chk_pass`=1.
- mismatch and retry_cnt<MAX_RETRY -> retry_cnt+1, back to RD_ID.
- mismatch and retry_cnt=MAX_RETRY -> DONE, with `chk_fail`=1.
REQ-011 retry_cnt SHALL be 4 bits and SHALL never wrap; it is cleared on reset and on an accepted `chk_start`.
REQ-012 `chk_done` SHALL be 1 only in DONE; `chk_pass` and `chk_fail` SHALL be mutually exclusive and held until reset or the next accepted `chk_start`.
REQ-013 `chk_busy` SHALL be 1 in RD_ID, RD_TS and COMPARE, and 0 otherwise.
REQ-014 `chk_start` SHALL be accepted only in DONE with no host read in flight; on acceptance it SHALL clear pass/fail/done and enter RD_ID next cycle. It SHALL be ignored in all other states.
REQ-015 `host_waitrequest` SHALL be combinational: 1 when state≠DONE, or a host read is in flight, or `chk_start`=1 in DONE (checker has priority over host on a same-cycle collision).
REQ-016 Host read handling:
- Accepted when `host_read`=1 and `host_waitrequest`=0.
- `host_address` latched on acceptance; one read outstanding.
- `sid_address` driven with the latched address for READ_LATENCY+1 cycles, starting in the acceptance cycle.
- `sid_readdata` sampled at the last of those cycles.
REQ-017 `host_readdatavalid` SHALL pulse for exactly one cycle, the cycle after sampling, with the sampled value registered on `host_readdata`; the in-flight flag SHALL clear in that same cycle.
REQ-018 `sid_address` SHALL be 0 whenever neither the checker nor a host read drives it.
REQ-019 `host_readdata` SHALL hold its last value between strobes.

Reset
REQ-020 On `reset`=1 at a clock edge, from any state including mid-phase or with a host read in flight, the block SHALL:
- go to IDLE;
- clear the phase counter, retry_cnt and in-flight flag;
- drive `chk_busy`, `chk_done`, `chk_pass`, `chk_fail`, `host_readdatavalid`, `sid_address` to 0;
- drive `id_value`, `ts_value`, `host_readdata` to 0;
- drive `host_waitrequest` to 1.
REQ-021 An in-flight host read interrupted by reset SHALL produce no `host_readdatavalid`.

Verification
REQ-022 Matching slave (addr0=0, addr1=1539181635), L=1: release reset at cycle 0 -> RD_ID cycles 1-2, RD_TS 3-4, COMPARE 5; cycle 6 `chk_done`=1, `chk_pass`=1, `ts_value`=1539181635.
REQ-023 addr0 returns 5, MAX_RETRY=2 -> three full read passes, then `chk_fail`=1, `chk_pass`=0, `id_value`=5.
REQ-024 L=0: DONE, `host_read`=1, `host_address`=1 -> `sid_address`=1 for one cycle; next cycle `host_readdatavalid`=1, `host_readdata`=1539181635; `host_waitrequest`=1 during the strobe cycle only.
REQ-025 In DONE, assert `chk_start` and `host_read` in the same cycle -> host not accepted (`host_waitrequest`=1), checker re-enters RD_ID, `chk_done` drops next cycle.
REQ-026 Assert `reset` in RD_TS and separately during a host read with L=3 -> all outputs at reset values, no `host_readdatavalid`, new auto-check starts after release.
REQ-027 Mismatch on first pass and match on the second -> `chk_pass`=1 with retry_cnt=1, and no `chk_fail` pulse at any time.
